// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forwarding resolver for the 5-stage pipeline,
// with a small FSM that holds a long multiply in Execute for MUL_LAT cycles.
module hazard_unit #(
    parameter int MUL_LAT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] RA1D,
    input  logic [3:0] RA2D,
    input  logic [3:0] RA1E,
    input  logic [3:0] RA2E,
    input  logic [3:0] WA3E,
    input  logic [3:0] WA3M,
    input  logic [3:0] WA3W,
    input  logic [3:0] WA4M,
    input  logic [3:0] WA4W,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       RegWrite2M,
    input  logic       RegWrite2W,
    input  logic       MemToRegE,
    input  logic       LongE,
    input  logic       PCSrcD,
    input  logic       PCSrcE,
    input  logic       PCSrcM,
    input  logic       PCSrcW,
    input  logic       BranchTakenE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic [2:0] ForwardAE,
    output logic [2:0] ForwardBE,
    output logic       BusyE
);
    typedef enum logic {IDLE, BUSY} state_t;

    // MUL_LAT==1 never enters BUSY, so the wrapped value is never loaded.
    localparam logic [3:0] LAT_M2 = 4'(MUL_LAT - 2);
    localparam logic       MULTI  = MUL_LAT > 1;

    state_t     r_state, w_next;
    logic [3:0] r_cnt, w_cnt_next;
    logic       w_mulstall, w_ldrstall, w_pcwr;

    function automatic logic [2:0] fwd(input logic [3:0] src);
        if (src == 4'd15)                return 3'b000;
        if (RegWriteM  && WA3M == src)   return 3'b010;
        if (RegWrite2M && WA4M == src)   return 3'b100;
        if (RegWriteW  && WA3W == src)   return 3'b001;
        if (RegWrite2W && WA4W == src)   return 3'b011;
        return 3'b000;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        if (r_state == IDLE) begin
            if (LongE && MULTI) begin
                w_next     = BUSY;
                w_cnt_next = LAT_M2;
            end
        end else if (r_cnt != 4'd0) begin
            w_cnt_next = r_cnt - 4'd1;
        end else begin
            w_next = IDLE;
        end
    end

    assign w_mulstall = (r_state == BUSY) ? (r_cnt != 4'd0) : (LongE && MULTI);
    assign w_ldrstall = MemToRegE && (WA3E == RA1D || WA3E == RA2D);
    assign w_pcwr     = PCSrcD | PCSrcE | PCSrcM;

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        FlushM    = 1'b1;
        ForwardAE = 3'b000;
        ForwardBE = 3'b000;
        BusyE     = 1'b0;
        if (!reset) begin
            StallF    = w_mulstall | w_ldrstall | w_pcwr;
            StallD    = w_mulstall | w_ldrstall;
            StallE    = w_mulstall;
            FlushM    = w_mulstall;
            FlushD    = !w_mulstall && (w_pcwr || PCSrcW || BranchTakenE);
            FlushE    = !w_mulstall && (w_ldrstall || BranchTakenE);
            ForwardAE = fwd(RA1E);
            ForwardBE = fwd(RA2E);
            BusyE     = r_state == BUSY;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and random checks of hazard_unit (MUL_LAT 3 and 1)
// against an occupancy-age behavioural model.
module tb_hazard_unit;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W, WA4M, WA4W;
    logic       RegWriteM, RegWriteW, RegWrite2M, RegWrite2W;
    logic       MemToRegE, LongE, PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;

    logic       sf3, sd3, se3, fd3, fe3, fm3, bz3;
    logic [2:0] fa3, fb3;
    logic       sf1, sd1, se1, fd1, fe1, fm1, bz1;
    logic [2:0] fa1, fb1;

    int checks = 0;
    int failures = 0;
    int age3 = -1;
    int age1 = -1;

    always #5 clk = ~clk;

    hazard_unit #(.MUL_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .WA4M(WA4M), .WA4W(WA4W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .RegWrite2M(RegWrite2M),
        .RegWrite2W(RegWrite2W), .MemToRegE(MemToRegE), .LongE(LongE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE), .StallF(sf3), .StallD(sd3), .StallE(se3),
        .FlushD(fd3), .FlushE(fe3), .FlushM(fm3), .ForwardAE(fa3), .ForwardBE(fb3),
        .BusyE(bz3)
    );

    hazard_unit #(.MUL_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .WA4M(WA4M), .WA4W(WA4W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .RegWrite2M(RegWrite2M),
        .RegWrite2W(RegWrite2W), .MemToRegE(MemToRegE), .LongE(LongE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE), .StallF(sf1), .StallD(sd1), .StallE(se1),
        .FlushD(fd1), .FlushE(fe1), .FlushM(fm1), .ForwardAE(fa1), .ForwardBE(fb1),
        .BusyE(bz1)
    );

    wire [12:0] v3 = {sf3, sd3, se3, fd3, fe3, fm3, bz3, fa3, fb3};
    wire [12:0] v1 = {sf1, sd1, se1, fd1, fe1, fm1, bz1, fa1, fb1};

    // Forward source: first matching writer in stage/priority order.
    function automatic logic [2:0] mfwd(input logic [3:0] s);
        logic [2:0] code [4];
        logic       en   [4];
        logic [3:0] dst  [4];
        code = '{3'b010, 3'b100, 3'b001, 3'b011};
        en   = '{RegWriteM, RegWrite2M, RegWriteW, RegWrite2W};
        dst  = '{WA3M, WA4M, WA3W, WA4W};
        if (s == 4'd15) return 3'b000;
        for (int i = 0; i < 4; i++)
            if (en[i] && dst[i] == s) return code[i];
        return 3'b000;
    endfunction

    // age = cycles the current multiply has already spent in Execute (-1: none)
    function automatic int eff_age(input int age);
        return age >= 0 ? age : (LongE ? 0 : -1);
    endfunction

    function automatic int next_age(input int lat, input int age);
        int e;
        e = eff_age(age);
        if (reset || e < 0 || e + 1 >= lat) return -1;
        return e + 1;
    endfunction

    function automatic logic [12:0] model(input int lat, input int age);
        int   e;
        logic ms, ldr, pcw;
        e   = eff_age(age);
        ms  = e >= 0 && e < lat - 1;
        ldr = MemToRegE && (WA3E == RA1D || WA3E == RA2D);
        pcw = PCSrcD | PCSrcE | PCSrcM;
        if (reset) return 13'b0001110_000000;
        return {ms | ldr | pcw, ms | ldr, ms, !ms && (pcw || PCSrcW || BranchTakenE),
                !ms && (ldr || BranchTakenE), ms, age >= 1, mfwd(RA1E), mfwd(RA2E)};
    endfunction

    always @(posedge clk) begin
        age3 <= next_age(3, age3);
        age1 <= next_age(1, age1);
    end

    task automatic chk(input string nm, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        chk("model_lat3", v3, model(3, age3));
        chk("model_lat1", v1, model(1, age1));
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W, WA4M, WA4W} = '0;
        {RegWriteM, RegWriteW, RegWrite2M, RegWrite2W} = '0;
        {MemToRegE, LongE, PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE} = '0;
    endtask

    initial begin
        clr();
        reset = 1'b1;
        settle(); chk("reset_vec", v3, 13'b0001110_000000); adv();
        settle(); adv();
        reset = 1'b0;
        RA1E = 4'd2; RegWriteM = 1'b1; WA3M = 4'd2; RegWriteW = 1'b1; WA3W = 4'd2;
        settle(); chk("fwd_m_over_w", v3, 13'b0000000_010000); adv();
        RegWriteM = 1'b0;
        settle(); chk("fwd_w", v3, 13'b0000000_001000); adv();
        RA1E = 4'd15;
        settle(); chk("fwd_r15", v3, 13'b0000000_000000); adv();
        clr(); MemToRegE = 1'b1; WA3E = 4'd3; RA2D = 4'd3;
        settle(); chk("load_use", v3, 13'b1100100_000000); adv();
        clr(); RegWriteM = 1'b1; WA3M = 4'd3; RA2E = 4'd3;
        settle(); chk("load_fwd", v3, 13'b0000000_000010); adv();
        clr(); BranchTakenE = 1'b1;
        settle(); chk("branch", v3, 13'b0001100_000000); adv();
        clr(); PCSrcD = 1'b1;
        settle(); chk("pcsrcd", v3, 13'b1001000_000000); adv();
        clr(); LongE = 1'b1;
        for (int r = 0; r < 2; r++) begin
            settle(); chk("mul_c0", v3, 13'b1110010_000000); chk("mul1_c0", v1, 13'b0); adv();
            settle(); chk("mul_c1", v3, 13'b1110011_000000); chk("mul1_c1", v1, 13'b0); adv();
            settle(); chk("mul_c2", v3, 13'b0000001_000000); adv();
        end
        LongE = 1'b0;
        settle(); chk("mul_done", v3, 13'b0); adv();
        clr(); RegWriteM = 1'b1; WA3M = 4'd4; RegWrite2M = 1'b1; WA4M = 4'd5;
        RA1E = 4'd5; RA2E = 4'd4;
        settle(); chk("umull_fwd", v3, 13'b0000000_100010); adv();
        clr(); LongE = 1'b1;
        settle(); chk("rst_mul_c0", v3, 13'b1110010_000000); adv();
        reset = 1'b1;
        settle(); chk("rst_mid_busy", v3, 13'b0001110_000000); adv();
        reset = 1'b0; LongE = 1'b0;
        settle(); chk("rst_after", v3, 13'b0); adv();
        LongE = 1'b1;
        settle(); chk("rst_mul2_c0", v3, 13'b1110010_000000); adv();
        settle(); chk("rst_mul2_c1", v3, 13'b1110011_000000); adv();
        settle(); chk("rst_mul2_c2", v3, 13'b0000001_000000); adv();
        for (int n = 0; n < 400; n++) begin
            reset      = $urandom_range(0, 24) == 0;
            RA1D       = 4'($urandom_range(0, 4)) | ($urandom_range(0, 7) == 0 ? 4'hF : 4'h0);
            RA2D       = 4'($urandom_range(0, 4));
            RA1E       = $urandom_range(0, 7) == 0 ? 4'd15 : 4'($urandom_range(0, 4));
            RA2E       = $urandom_range(0, 7) == 0 ? 4'd15 : 4'($urandom_range(0, 4));
            WA3E       = 4'($urandom_range(0, 4));
            WA3M       = 4'($urandom_range(0, 4));
            WA3W       = 4'($urandom_range(0, 4));
            WA4M       = $urandom_range(0, 5) == 0 ? 4'd15 : 4'($urandom_range(0, 4));
            WA4W       = 4'($urandom_range(0, 4));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            RegWrite2M = 1'($urandom_range(0, 1));
            RegWrite2W = 1'($urandom_range(0, 1));
            MemToRegE  = $urandom_range(0, 3) == 0;
            LongE      = $urandom_range(0, 2) == 0;
            PCSrcD     = $urandom_range(0, 7) == 0;
            PCSrcE     = $urandom_range(0, 7) == 0;
            PCSrcM     = $urandom_range(0, 7) == 0;
            PCSrcW     = $urandom_range(0, 7) == 0;
            BranchTakenE = !LongE && $urandom_range(0, 5) == 0;
            settle();
            adv();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard resolver for the 5-stage ARM core. It consumes the per-stage control bits the controller produces (RegWrite/PCSrc/MemToReg/Long) and the datapath register addresses. It returns the stall, flush and forwarding selects that drive the pipeline registers and the Execute operand muxes. It also owns a small FSM that holds a long/multiply instruction in Execute for `MUL_LAT` cycles.

## Interface
- `MUL_LAT`, default 3: cycles a `LongE` instruction occupies Execute; legal range 1..15.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `RA1D`, `RA2D` in 4: source registers of the Decode instruction.
- `RA1E`, `RA2E` in 4: source registers of the Execute instruction.
- `WA3E` in 4: destination register in Execute.
- `WA3M`, `WA3W` in 4: primary destination in Memory and Writeback.
- `WA4M`, `WA4W` in 4: secondary destination (long multiply high word / writeback base) in Memory and Writeback.
- `RegWriteM`, `RegWriteW`, `RegWrite2M`, `RegWrite2W` in 1: write enables matching the above.
- `MemToRegE` in 1: Execute instruction is a load.
- `LongE` in 1: Execute instruction is multi-cycle.
- `PCSrcD`, `PCSrcE`, `PCSrcM`, `PCSrcW` in 1: instruction writes PC, per stage.
- `BranchTakenE` in 1: branch resolved taken in Execute.
- `StallF`, `StallD`, `StallE` out 1: hold the register feeding that stage.
- `FlushD`, `FlushE`, `FlushM` out 1: clear the register feeding that stage.
- `ForwardAE`, `ForwardBE` out 3: operand select for SrcA and SrcB in Execute.
- `BusyE` out 1: multiply FSM in BUSY.

## Operation
- Forwarding, per operand X∈{A,B} with source `RAXE`:
  - Encoding: 3'b010 ALUResultM (`RegWriteM` & `WA3M`==src); 3'b100 Result2M (`RegWrite2M` & `WA4M`==src); 3'b001 ResultW (`RegWriteW` & `WA3W`==src); 3'b011 Result2W (`RegWrite2W` & `WA4W`==src); else 3'b000.
  - Priority is top to bottom: the Memory stage wins over Writeback, and primary wins over secondary within a stage.
  - Source register 15 never forwards; it always yields 3'b000.
- Load-use: `LDRstall` = `MemToRegE` & (`WA3E`==`RA1D` | `WA3E`==`RA2D`).
- `PCWrPending` = `PCSrcD` | `PCSrcE` | `PCSrcM`.
- Multiply FSM, states IDLE and BUSY, with a 4-bit counter `cnt`:
  - IDLE & `LongE` & `MUL_LAT`>1: `mulstall`=1; `cnt`<=`MUL_LAT`-2; go to BUSY.
  - IDLE & `LongE` & `MUL_LAT`==1: no stall; stay in IDLE.
  - BUSY: `mulstall` = (`cnt`!=0). If `cnt`!=0, decrement. If `cnt`==0, go to IDLE; the instruction leaves Execute at this edge.
  - `LongE` is honoured regardless of condition pass/fail.
- Outputs when `mulstall`=1:
  - `StallF`=`StallD`=`StallE`=1 and `FlushM`=1, so a bubble enters Memory and the multiply is never duplicated.
  - `FlushD`=`FlushE`=0, since Decode holds.
- Outputs when `mulstall`=0:
  - `StallF` = `LDRstall` | `PCWrPending`.
  - `StallD` = `LDRstall`.
  - `StallE`=0, `FlushM`=0.
  - `FlushD` = `PCWrPending` | `PCSrcW` | `BranchTakenE`.
  - `FlushE` = `LDRstall` | `BranchTakenE`.
- `LDRstall` and `mulstall` are mutually exclusive because Execute holds one instruction.
- `BranchTakenE` and `LongE` never coincide.

## Timing
- Forwarding, load-use and flush terms are combinational from the inputs, with zero latency.
- `mulstall` is a function of the registered state plus `LongE`.
- A multiply occupies Execute for exactly `MUL_LAT` cycles and asserts stalls for `MUL_LAT`-1 cycles, starting the cycle `LongE` first appears.
- Back-to-back multiplies: when BUSY exits with `cnt`==0, the next cycle is IDLE. A new `LongE` there starts a fresh sequence with no gap.
- `reset`=1 (sampled at the edge): state<=IDLE and `cnt`<=0, including when reset arrives mid-BUSY.
- While `reset` is high, the outputs are forced:
  - `Stall*`=0 and `BusyE`=0.
  - `FlushD`=`FlushE`=`FlushM`=1.
  - `ForwardAE`=`ForwardBE`=3'b000.
- After reset is released, the first cycle is IDLE.

## Test plan
- ADD writes R2 (in M) while an Execute SUB reads R2 on RA1E, and the W stage also writes R2 → `ForwardAE`=3'b010. Remove the M write → 3'b001. Set RA1E=15 → 3'b000.
- LDR R3 in E with `RA2D`=3 → `StallF`=`StallD`=`FlushE`=1 for one cycle. Next cycle the load is in M → `ForwardBE`=3'b010 and the stalls drop.
- `BranchTakenE`=1 → `FlushD`=`FlushE`=1 and `StallF`=0. `PCSrcD`=1 alone → `StallF`=1, `FlushD`=1, `FlushE`=0.
- `MUL_LAT`=3, `LongE` held → `StallF`/`StallD`/`StallE`/`FlushM` high for exactly 2 cycles and `BusyE` high for 2 cycles, then released. A second `LongE` immediately after → 2 more stall cycles. `MUL_LAT`=1 → no stall.
- UMULL writes R4/R5 via WA3M/WA4M with RA1E=5, RA2E=4 → `ForwardAE`=3'b100 and `ForwardBE`=3'b010.
- Assert `reset` during the first BUSY cycle → `BusyE`=0 next cycle, stalls deasserted, flushes high. After release, `LongE` starts a full `MUL_LAT`-1 stall.
